uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter between NUM_REQ independent requesters using round-robin arbitration.
- Each requester presents a byte and its own frame format (stop bits, parity).
- The arbiter latches the winner, issues a single-cycle write to the transmitter, and confirms acceptance by watching tx busy.
- It then holds off further grants until the frame has fully left the line.
- Sits between the transmitter and the host-side producers (command engine, debug console, status reporter).

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ACK_TIMEOUT, 4, cycles to wait for tx_busy_i to rise after a write before abandoning the attempt.

Ports:
clock_i  input  1  system clock.
reset_ni  input  1  asynchronous active-low reset.
req_valid_i  input  NUM_REQ  per-requester request; held until req_ack_o for that requester.
req_data_i  input  8*NUM_REQ  byte for requester k in bits [8k+7:8k].
req_two_stop_bits_i  input  NUM_REQ  per-requester two-stop-bit select.
req_parity_bit_i  input  NUM_REQ  per-requester parity enable.
req_parity_even_i  input  NUM_REQ  per-requester even(1)/odd(0) parity.
req_ack_o  output  NUM_REQ  one-hot, one-cycle pulse: byte accepted by transmitter.
grant_o  output  NUM_REQ  one-hot current owner; 0 when idle.
tx_data_o  output  8  to uart_tx data_i.
tx_write_o  output  1  to uart_tx write_i.
tx_two_stop_bits_o  output  1  to uart_tx two_stop_bits_i.
tx_parity_bit_o  output  1  to uart_tx parity_bit_i.
tx_parity_even_o  output  1  to uart_tx parity_even_i.
tx_busy_i  input  1  from uart_tx busy_o.
busy_o  output  1  arbiter not in IDLE.
timeout_o  output  1  sticky: an ACK_TIMEOUT expiry has occurred.

Behaviour:
- Reset (reset_ni low, async): state=IDLE, rr pointer=NUM_REQ-1, all outputs 0, timeout_o=0. All outputs are registered.
- IDLE: when tx_busy_i=0 and any req_valid_i is set, pick the first valid index searching from pointer+1 modulo NUM_REQ.
  - Latch index, data and the three format bits into tx_* registers.
  - Set grant_o to the chosen index, then go to ISSUE.
  - If tx_busy_i=1 (including the transmitter's post-reset hold-off), stay in IDLE.
- ISSUE (exactly 1 cycle): tx_write_o=1. Clear the timer, then go to WAIT_ACK.
- WAIT_ACK: tx_write_o=0. This guarantees the write-low-between-writes rule.
  - If tx_busy_i=1: pulse req_ack_o[grant] for one cycle (registered, visible the next cycle), move the pointer to the granted index, go to WAIT_DONE.
  - Otherwise increment the timer. At ACK_TIMEOUT: set timeout_o, clear grant_o, go to IDLE with the pointer unchanged. No ack is issued, so the requester retries.
- WAIT_DONE: hold grant_o and tx_* stable. When tx_busy_i=0, clear grant_o and go to IDLE.
  - Earliest next grant is the following cycle, giving back-to-back frames with no idle gap beyond the transmitter's own.
- Latency: request seen in IDLE at cycle T gives tx_write_o=1 at T+1. tx_busy_i rises at T+2, req_ack_o pulses at T+3.
- Requester rules:
  - req_valid_i and data must stay stable until ack.
  - Valid sampled the cycle after ack is a new request.
  - Dropping valid before ack is allowed only while not granted. Once granted, the byte is sent regardless.
- Fairness: the pointer advances only on a successful ack. With all NUM_REQ valid, grants rotate 0,1,2,...,NUM_REQ-1,0.
- Simultaneous events:
  - New valid bits arriving in any non-IDLE state are ignored until IDLE.
  - An ack and a new valid on the same requester in the same cycle: the valid counts as the next request.
- Unknown state encoding goes to IDLE.

Decomposition:
- Shared package uart_pkg: arbiter state enum (IDLE, ISSUE, WAIT_ACK, WAIT_DONE) and a default frame-format struct (two_stop, parity, even).
- One sub-module: rr_pick. It is combinational; inputs are the valid vector and the pointer; outputs are the one-hot winner and its index.

Test Plan:
- Single request, req0 data 8'hA5, no parity, one stop, tx divider 1: tx_write_o high for 1 cycle at T+1, req_ack_o=4'b0001 at T+3, grant held until busy falls, serial line shows frame 0,10100101,1.
- All four requesters valid continuously, data 8'h10..8'h13: transmitted order is 10,11,12,13,10; exactly one ack per frame; tx_write_o returns to 0 between every write.
- req2 with parity even, data 8'h07: tx_parity_bit_o=1 and tx_parity_even_o=1 latched, serial parity bit =1, 11-bit frame.
- Transmitter held in reset (busy stuck high) after arbiter reset: arbiter stays in IDLE with no write. Release transmitter reset: no write until post-reset busy clears, then grant.
- tx_busy_i forced 0 after ISSUE: after 4 cycles timeout_o=1, no ack, pointer unchanged, same requester regranted.
- reset_ni low during WAIT_DONE: all outputs 0 immediately (async), state IDLE, timeout_o cleared.

Source files
------------

// File: rtl/uart_pkg.sv
// Types shared by the UART transmit arbiter and its helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic two_stop;
        logic parity;
        logic even;
    } frame_fmt_t;

    localparam frame_fmt_t FRAME_FMT_DEFAULT = '{two_stop: 1'b0, parity: 1'b0, even: 1'b0};

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index strictly after the pointer, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               found_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk ptr+1 .. ptr+NUM_REQ so the last owner gets lowest priority.
    always_comb begin
        winner_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!found && valid_i[cand]) begin
                found          = 1'b1;
                winner_o[cand] = 1'b1;
                idx_o          = cand;
            end
        end
    end

    assign found_o = found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ requesters, each with its own frame format.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                 clock_i,
    input  logic                 reset_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_two_stop_bits_i,
    input  logic [NUM_REQ-1:0]   req_parity_bit_i,
    input  logic [NUM_REQ-1:0]   req_parity_even_i,
    output logic [NUM_REQ-1:0]   req_ack_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_write_o,
    output logic                 tx_two_stop_bits_o,
    output logic                 tx_parity_bit_o,
    output logic                 tx_parity_even_o,
    input  logic                 tx_busy_i,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [7:0]         data_q, data_d;
    frame_fmt_t         fmt_q, fmt_d;
    logic               write_q, write_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid_i  (req_valid_i),
        .ptr_i    (ptr_q),
        .winner_o (win_onehot),
        .idx_o    (win_idx),
        .found_o  (win_found)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        grant_d   = grant_q;
        ack_d     = '0;
        data_d    = data_q;
        fmt_d     = fmt_q;
        write_d   = 1'b0;
        timeout_d = timeout_q;
        timer_d   = timer_q;

        case (state_q)
            IDLE: begin
                if (!tx_busy_i && win_found) begin
                    idx_d   = win_idx;
                    grant_d = win_onehot;
                    data_d  = req_data_i[{win_idx, 3'b000} +: 8];
                    fmt_d   = '{two_stop: req_two_stop_bits_i[win_idx],
                                parity:   req_parity_bit_i[win_idx],
                                even:     req_parity_even_i[win_idx]};
                    write_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Busy rising is the transmitter's only acceptance signal.
                if (tx_busy_i) begin
                    ack_d   = grant_q;
                    ptr_d   = idx_q;
                    state_d = WAIT_DONE;
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_RESET;
            idx_q     <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            data_q    <= '0;
            fmt_q     <= FRAME_FMT_DEFAULT;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
            fmt_q     <= fmt_d;
            write_q   <= write_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            timer_q   <= timer_d;
        end
    end

    assign req_ack_o          = ack_q;
    assign grant_o            = grant_q;
    assign tx_data_o          = data_q;
    assign tx_write_o         = write_q;
    assign tx_two_stop_bits_o = fmt_q.two_stop;
    assign tx_parity_bit_o    = fmt_q.parity;
    assign tx_parity_even_o   = fmt_q.even;
    assign busy_o             = busy_q;
    assign timeout_o          = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural transmitter model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ACK_TIMEOUT = 4;
    localparam int POSTRST     = 6;

    logic                 clock_i  = 1'b0;
    logic                 reset_ni = 1'b0;
    logic [NUM_REQ-1:0]   req_valid_i = '0;
    logic [8*NUM_REQ-1:0] req_data_i = '0;
    logic [NUM_REQ-1:0]   req_two_stop_bits_i = '0;
    logic [NUM_REQ-1:0]   req_parity_bit_i = '0;
    logic [NUM_REQ-1:0]   req_parity_even_i = '0;
    logic [NUM_REQ-1:0]   req_ack_o;
    logic [NUM_REQ-1:0]   grant_o;
    logic [7:0]           tx_data_o;
    logic                 tx_write_o;
    logic                 tx_two_stop_bits_o;
    logic                 tx_parity_bit_o;
    logic                 tx_parity_even_o;
    logic                 tx_busy_i = 1'b0;
    logic                 busy_o;
    logic                 timeout_o;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clock_i             (clock_i),
        .reset_ni            (reset_ni),
        .req_valid_i         (req_valid_i),
        .req_data_i          (req_data_i),
        .req_two_stop_bits_i (req_two_stop_bits_i),
        .req_parity_bit_i    (req_parity_bit_i),
        .req_parity_even_i   (req_parity_even_i),
        .req_ack_o           (req_ack_o),
        .grant_o             (grant_o),
        .tx_data_o           (tx_data_o),
        .tx_write_o          (tx_write_o),
        .tx_two_stop_bits_o  (tx_two_stop_bits_o),
        .tx_parity_bit_o     (tx_parity_bit_o),
        .tx_parity_even_o    (tx_parity_even_o),
        .tx_busy_i           (tx_busy_i),
        .busy_o              (busy_o),
        .timeout_o           (timeout_o)
    );

    always #5 clock_i = ~clock_i;

    // Transmitter model: busy for one whole frame after an accepted write.
    logic tx_hold = 1'b0;
    logic tx_mute = 1'b0;
    int   tx_div  = 1;
    int   tx_cnt  = 0;

    always @(posedge clock_i) begin
        if (tx_hold) begin
            tx_busy_i <= 1'b1;
            tx_cnt    <= POSTRST - 1;
        end else if (tx_busy_i) begin
            if (tx_cnt == 0) tx_busy_i <= 1'b0;
            else             tx_cnt    <= tx_cnt - 1;
        end else if (tx_write_o && !tx_mute) begin
            tx_busy_i <= 1'b1;
            tx_cnt    <= (10 + int'(tx_parity_bit_o) + int'(tx_two_stop_bits_o)) * tx_div - 1;
        end
    end

    // Entries: {two_stop, parity, even, data}; expected adds the requester index on top.
    logic [10:0]        src_q [NUM_REQ][$];
    logic [10:0]        pend  [NUM_REQ][$];
    logic [13:0]        exp_q [$];
    logic [NUM_REQ-1:0] ack_q [$];
    int  n_cmp  = 0;
    int  n_bad  = 0;
    int  wr_cnt = 0;
    logic prev_wr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string msg);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", name, msg);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({req_ack_o, grant_o, tx_data_o, tx_write_o, tx_two_stop_bits_o,
                    tx_parity_bit_o, tx_parity_even_o, busy_o, timeout_o});
    endfunction

    task automatic drive_reqs();
        for (int k = 0; k < NUM_REQ; k++) begin
            if (src_q[k].size() > 0) begin
                req_valid_i[k]         = 1'b1;
                req_data_i[8*k +: 8]   = src_q[k][0][7:0];
                req_parity_even_i[k]   = src_q[k][0][8];
                req_parity_bit_i[k]    = src_q[k][0][9];
                req_two_stop_bits_i[k] = src_q[k][0][10];
            end else begin
                req_valid_i[k] = 1'b0;
            end
        end
    endtask

    task automatic driver();
        forever begin
            @(negedge clock_i);
            for (int k = 0; k < NUM_REQ; k++)
                if (req_ack_o[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            drive_reqs();
        end
    endtask

    task automatic monitor();
        logic [13:0] e;
        forever begin
            @(negedge clock_i);
            if (!reset_ni) begin
                exp_q.delete();
                ack_q.delete();
                prev_wr = 1'b0;
                continue;
            end
            if (tx_write_o) begin
                wr_cnt++;
                check("write_gap", 32'(prev_wr), 32'd0);
                if (exp_q.size() == 0) begin
                    fail("write_unexpected", "write with nothing expected");
                end else begin
                    e = tx_mute ? exp_q[0] : exp_q.pop_front();
                    check("write_grant", 32'(grant_o), 32'(1) << e[13:11]);
                    check("write_data", 32'(tx_data_o), 32'(e[7:0]));
                    check("write_fmt", 32'({tx_two_stop_bits_o, tx_parity_bit_o, tx_parity_even_o}),
                          32'(e[10:8]));
                    if (!tx_mute) ack_q.push_back(NUM_REQ'(1) << e[13:11]);
                end
            end
            if (req_ack_o != '0) begin
                if (ack_q.size() == 0) fail("ack_unexpected", "ack with no accepted write");
                else check("req_ack", 32'(req_ack_o), 32'(ack_q.pop_front()));
            end
            prev_wr = tx_write_o;
        end
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        int left;
        n = 0;
        forever begin
            left = exp_q.size() + ack_q.size();
            for (int k = 0; k < NUM_REQ; k++) left += src_q[k].size();
            if (!busy_o && !tx_busy_i && left == 0) return;
            if (n >= bound) begin
                fail(name, "did not drain in time");
                return;
            end
            @(negedge clock_i);
            n++;
        end
    endtask

    task automatic wait_write(input string name, input int bound);
        for (int n = 0; n < bound; n++) begin
            @(negedge clock_i);
            if (tx_write_o) return;
        end
        fail(name, "no write in time");
    endtask

    initial begin
        int wr_n, ack_n, w0, total, mdl_ptr, nb;
        logic [10:0] ent;

        fork
            monitor();
            driver();
            begin
                #400000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clock_i);
        check("reset_outputs", all_outs(), 32'd0);
        reset_ni = 1'b1;
        repeat (2) @(negedge clock_i);
        check("idle_outputs", all_outs(), 32'd0);

        // Single request: write one cycle after the request, ack two cycles later.
        src_q[0].push_back({3'b000, 8'hA5});
        exp_q.push_back({3'd0, 3'b000, 8'hA5});
        drive_reqs();
        wr_n  = 0;
        ack_n = 0;
        for (int n = 1; n <= 40 && ack_n == 0; n++) begin
            @(negedge clock_i);
            if (tx_write_o && wr_n == 0) wr_n = n;
            if (req_ack_o != '0) begin
                ack_n = n;
                check("grant_at_ack", 32'(grant_o), 32'b0001);
            end
        end
        check("write_latency", 32'(wr_n), 32'd1);
        check("ack_latency", 32'(ack_n), 32'd3);
        repeat (4) @(negedge clock_i);
        check("grant_held", 32'({busy_o, grant_o}), 32'b1_0001);
        wait_idle("single_done", 100);

        // Transmitter held busy: nothing issued until its busy clears.
        tx_hold = 1'b1;
        repeat (2) @(negedge clock_i);
        w0 = wr_cnt;
        src_q[2].push_back({3'b011, 8'h07});
        exp_q.push_back({3'd2, 3'b011, 8'h07});
        drive_reqs();
        repeat (15) @(negedge clock_i);
        check("hold_no_write", 32'(wr_cnt), 32'(w0));
        check("hold_idle", 32'({busy_o, grant_o}), 32'd0);
        tx_hold = 1'b0;
        for (int n = 0; n < 50 && tx_busy_i; n++) @(negedge clock_i);
        check("hold_release_no_write", 32'(wr_cnt), 32'(w0));
        wait_idle("parity_done", 200);
        check("parity_written", 32'(wr_cnt), 32'(w0 + 1));

        // Mute transmitter: timeout, no ack, same requester granted again.
        tx_mute = 1'b1;
        src_q[3].push_back({3'b000, 8'h3C});
        src_q[0].push_back({3'b100, 8'hC3});
        exp_q.push_back({3'd3, 3'b000, 8'h3C});
        exp_q.push_back({3'd0, 3'b100, 8'hC3});
        drive_reqs();
        wait_write("timeout_first_write", 20);
        repeat (ACK_TIMEOUT) @(negedge clock_i);
        check("timeout_not_yet", 32'(timeout_o), 32'd0);
        @(negedge clock_i);
        check("timeout_set", 32'({timeout_o, grant_o, req_ack_o}), 32'h100);
        wait_write("timeout_retry_write", 20);
        check("retry_grant", 32'(grant_o), 32'b1000);
        repeat (ACK_TIMEOUT + 1) @(negedge clock_i);
        check("retry_timeout_idle", 32'(grant_o), 32'd0);
        tx_mute = 1'b0;
        wait_idle("timeout_recover", 200);
        check("timeout_sticky", 32'(timeout_o), 32'd1);

        // Asynchronous reset while the frame is still on the line.
        src_q[1].push_back({3'b110, 8'h5A});
        exp_q.push_back({3'd1, 3'b110, 8'h5A});
        drive_reqs();
        ack_n = 0;
        for (int n = 0; n < 20 && ack_n == 0; n++) begin
            @(negedge clock_i);
            if (req_ack_o != '0) ack_n = 1;
        end
        if (ack_n == 0) fail("reset_case_ack", "no ack in time");
        repeat (2) @(negedge clock_i);
        check("wait_done_busy", 32'({busy_o, grant_o}), 32'b1_0010);
        #2 reset_ni = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 32'd0);
        repeat (2) @(negedge clock_i);
        reset_ni = 1'b1;
        wait_idle("post_reset", 200);

        // Batches: the first is all four requesters with 10..13 twice, the rest random.
        mdl_ptr = NUM_REQ - 1;
        for (int b = 0; b < 8; b++) begin
            tx_div = (b == 0) ? 1 : int'($urandom_range(1, 2));
            total  = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                nb = (b == 0) ? 2 : int'($urandom_range(0, 3));
                for (int j = 0; j < nb; j++) begin
                    ent = (b == 0) ? {3'b000, 8'h10 + 8'(k)} : 11'($urandom());
                    src_q[k].push_back(ent);
                    pend[k].push_back(ent);
                    total++;
                end
            end
            // Everyone with bytes left stays valid, so service order is pure rotation.
            while (total > 0) begin
                for (int i = 1; i <= NUM_REQ; i++) begin
                    int k;
                    k = (mdl_ptr + i) % NUM_REQ;
                    if (pend[k].size() > 0) begin
                        exp_q.push_back({3'(k), pend[k].pop_front()});
                        mdl_ptr = k;
                        break;
                    end
                end
                total--;
            end
            drive_reqs();
            wait_idle("batch_drain", 3000);
        end

        check("expected_drained", 32'(exp_q.size()), 32'd0);
        check("acks_drained", 32'(ack_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
